memory_io_stream_bridge: RTL and testbench

FPGA-side endpoint for the HPS memory-mapped bridge conduits (control, data-in, data-out).
- HPS fills a parametrised input buffer, writes LENGTH, then pulses START.
- The block streams the buffer to the compute core over valid/ready, and collects the core's results into an output buffer that the HPS reads back.
- It generalises the fixed 32-bit/256-word bridge to configurable width and depth, and adds a run controller with status and error reporting.

---
 rtl/memory_io_pkg.sv | 25 ++
 rtl/memory_io_dpram.sv | 38 +++
 rtl/memory_io_stream_bridge.sv | 274 +++++++++++++++++++++++++++
 tb/tb_memory_io_stream_bridge.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_io_pkg.sv
// Shared register map, control/status bit positions and run-controller states
// for the HPS memory-mapped stream bridge.
package memory_io_pkg;

  localparam int unsigned REG_CTRL      = 0;
  localparam int unsigned REG_LENGTH    = 1;
  localparam int unsigned REG_STATUS    = 2;
  localparam int unsigned REG_OUT_COUNT = 3;
  localparam int unsigned REG_CYCLES    = 4;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_CLR   = 1;

  localparam int unsigned STS_BUSY    = 0;
  localparam int unsigned STS_DONE    = 1;
  localparam int unsigned STS_ERR_LEN = 2;
  localparam int unsigned STS_ERR_WR  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/memory_io_dpram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
// Latency: read data 1 cycle after rd_en_i; a same-address read and write return the old word.
// Backpressure: none, both ports accept every cycle.
module memory_io_dpram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_dat_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_dat_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_dat_q;

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_dat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_dat_q <= '0;
    end else if (rd_en_i) begin
      rd_dat_q <= mem[rd_addr_i];
    end
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/memory_io_stream_bridge.sv
// HPS bridge endpoint: buffers a job, streams it to the core and collects results (CYCLES via MEMORY_IO_CYCLE_COUNTER_EN).
// Latency: register and data_out reads 1 cycle; first src word 2 cycles after START, then 1 word/clk.
// Backpressure: src held stable while !src_ready (2-entry skid keeps full rate); snk_ready drops once LENGTH results stored.
module memory_io_stream_bridge
  import memory_io_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int CTRL_ADDR_W = 8
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic                   data_in_write,
  input  logic [DATA_W-1:0]      data_in_writedata,
  input  logic [ADDR_W-1:0]      data_in_address,
  input  logic [ADDR_W-1:0]      data_out_address,
  output logic [DATA_W-1:0]      data_out_readdata,
  input  logic [CTRL_ADDR_W-1:0] data_control_address,
  input  logic                   data_control_read,
  input  logic                   data_control_write,
  input  logic [31:0]            data_control_writedata,
  output logic [31:0]            data_control_readdata,
  output logic                   src_valid,
  output logic [DATA_W-1:0]      src_data,
  output logic                   src_last,
  input  logic                   src_ready,
  input  logic                   snk_valid,
  input  logic [DATA_W-1:0]      snk_data,
  output logic                   snk_ready
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int          CW    = ADDR_W + 1;
  typedef logic [CW-1:0] cnt_t;

  state_t            state_q, state_d;
  logic [31:0]       length_q, length_d;
  cnt_t              len_q, len_d;
  cnt_t              in_cnt_q, in_cnt_d;
  cnt_t              out_cnt_q, out_cnt_d;
  cnt_t              rd_ptr_q, rd_ptr_d;
  logic              src_vld_q, src_vld_d;
  logic [DATA_W-1:0] src_dat_q, src_dat_d;
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
  logic              rd_pend_q, rd_pend_d;
  logic              done_q, done_d;
  logic              err_len_q, err_len_d;
  logic              err_wr_q, err_wr_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [DATA_W-1:0] in_rd_dat;
  logic [31:0]       cyc_rd;
  logic [3:0]        status;
  logic [1:0]        occ;
  int unsigned       reg_off;
  logic busy, ctrl_wr, start, clr, len_ok, start_ok;
  logic pop, snk_fire, issue, run_done;

  assign reg_off  = 32'(data_control_address);
  assign busy     = (state_q != ST_IDLE);
  assign ctrl_wr  = data_control_write && (reg_off == REG_CTRL);
  assign start    = ctrl_wr && data_control_writedata[CTRL_START];
  assign clr      = ctrl_wr && data_control_writedata[CTRL_CLR];
  assign len_ok   = (length_q != '0) && (length_q <= DEPTH);
  assign start_ok = start && !busy && len_ok;

  assign pop      = src_vld_q && src_ready;
  assign snk_fire = snk_valid && snk_ready;
  // Words held or in flight after this edge; a new read is issued only if it has a slot to land in.
  assign occ      = 2'(src_vld_q) + 2'(skid_vld_q) + 2'(rd_pend_q) - 2'(pop);
  assign issue    = busy && (rd_ptr_q < len_q) && (occ < 2'd2);
  assign run_done = (state_q == ST_RUN) && (in_cnt_q == len_q) && (out_cnt_q == len_q);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    src_vld_d  = src_vld_q;
    src_dat_d  = src_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    rd_pend_d  = issue;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d   = ST_PRIME;
          len_d     = length_q[CW-1:0];
          in_cnt_d  = '0;
          out_cnt_d = '0;
          rd_ptr_d  = '0;
        end
      end
      ST_PRIME: state_d = ST_RUN;
      ST_RUN: begin
        if (run_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      rd_ptr_d = rd_ptr_q + cnt_t'(1);
    end
    if (pop) begin
      in_cnt_d = in_cnt_q + cnt_t'(1);
    end
    if (snk_fire) begin
      out_cnt_d = out_cnt_q + cnt_t'(1);
    end

    // Head refills from the skid first, then from the word arriving from RAM.
    if (pop || !src_vld_q) begin
      if (skid_vld_q) begin
        src_vld_d  = 1'b1;
        src_dat_d  = skid_dat_q;
        skid_vld_d = rd_pend_q;
        if (rd_pend_q) begin
          skid_dat_d = in_rd_dat;
        end
      end else begin
        src_vld_d = rd_pend_q;
        if (rd_pend_q) begin
          src_dat_d = in_rd_dat;
        end
      end
    end else if (rd_pend_q) begin
      skid_vld_d = 1'b1;
      skid_dat_d = in_rd_dat;
    end
  end

  always_comb begin
    length_d  = length_q;
    done_d    = done_q;
    err_len_d = err_len_q;
    err_wr_d  = err_wr_q;

    if (data_control_write && (reg_off == REG_LENGTH)) begin
      length_d = data_control_writedata;
    end
    // CLR lands first so a combined CLR+START still reports a length error.
    if (clr) begin
      done_d    = 1'b0;
      err_len_d = 1'b0;
      err_wr_d  = 1'b0;
    end
    if (start_ok) begin
      done_d = 1'b0;
    end
    if (start && !busy && !len_ok) begin
      err_len_d = 1'b1;
    end
    if (data_in_write && busy) begin
      err_wr_d = 1'b1;
    end
    if (run_done) begin
      done_d = 1'b1;
    end
  end

  always_comb begin
    status              = '0;
    status[STS_BUSY]    = busy;
    status[STS_DONE]    = done_q;
    status[STS_ERR_LEN] = err_len_q;
    status[STS_ERR_WR]  = err_wr_q;

    rdata_d = rdata_q;
    if (data_control_read) begin
      case (reg_off)
        REG_LENGTH:    rdata_d = length_q;
        REG_STATUS:    rdata_d = 32'(status);
        REG_OUT_COUNT: rdata_d = 32'(out_cnt_q);
        REG_CYCLES:    rdata_d = cyc_rd;
        default:       rdata_d = '0;
      endcase
    end
  end

`ifdef MEMORY_IO_CYCLE_COUNTER_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (start_ok) begin
      cyc_d = '0;
    end else if (busy && (cyc_q != '1)) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cyc_rd = cyc_q;
`else
  assign cyc_rd = '0;
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= ST_IDLE;
      length_q   <= '0;
      len_q      <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      rd_ptr_q   <= '0;
      src_vld_q  <= 1'b0;
      src_dat_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      rd_pend_q  <= 1'b0;
      done_q     <= 1'b0;
      err_len_q  <= 1'b0;
      err_wr_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      length_q   <= length_d;
      len_q      <= len_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      src_vld_q  <= src_vld_d;
      src_dat_q  <= src_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      rd_pend_q  <= rd_pend_d;
      done_q     <= done_d;
      err_len_q  <= err_len_d;
      err_wr_q   <= err_wr_d;
      rdata_q    <= rdata_d;
    end
  end

  memory_io_dpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_in_ram (
    .clk_i     (clk_clk),
    .rst_n_i   (reset_reset_n),
    .wr_en_i   (data_in_write && !busy),
    .wr_addr_i (data_in_address),
    .wr_dat_i  (data_in_writedata),
    .rd_en_i   (issue),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_dat_o  (in_rd_dat)
  );

  memory_io_dpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_out_ram (
    .clk_i     (clk_clk),
    .rst_n_i   (reset_reset_n),
    .wr_en_i   (snk_fire),
    .wr_addr_i (out_cnt_q[ADDR_W-1:0]),
    .wr_dat_i  (snk_data),
    .rd_en_i   (1'b1),
    .rd_addr_i (data_out_address),
    .rd_dat_o  (data_out_readdata)
  );

  assign src_valid             = src_vld_q;
  assign src_data              = src_dat_q;
  assign src_last              = src_vld_q && (in_cnt_q == (len_q - cnt_t'(1)));
  assign snk_ready             = (state_q == ST_RUN) && (out_cnt_q < len_q);
  assign data_control_readdata = rdata_q;

endmodule

// File: tb/tb_memory_io_stream_bridge.sv
// Bench for memory_io_stream_bridge: register table, then jobs driven by a +1 core model
// with randomized handshakes, checked against a queue/array model of the buffers.
module tb_memory_io_stream_bridge;

  localparam int DEPTH = 256;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        data_in_write;
  logic [31:0] data_in_writedata;
  logic [7:0]  data_in_address;
  logic [7:0]  data_out_address;
  logic [31:0] data_out_readdata;
  logic [7:0]  data_control_address;
  logic        data_control_read;
  logic        data_control_write;
  logic [31:0] data_control_writedata;
  logic [31:0] data_control_readdata;
  logic        src_valid;
  logic [31:0] src_data;
  logic        src_last;
  logic        src_ready;
  logic        snk_valid;
  logic [31:0] snk_data;
  logic        snk_ready;

  memory_io_stream_bridge #(.DATA_W(32), .ADDR_W(8), .CTRL_ADDR_W(8)) dut (
    .clk_clk                (clk_clk),
    .reset_reset_n          (reset_reset_n),
    .data_in_write          (data_in_write),
    .data_in_writedata      (data_in_writedata),
    .data_in_address        (data_in_address),
    .data_out_address       (data_out_address),
    .data_out_readdata      (data_out_readdata),
    .data_control_address   (data_control_address),
    .data_control_read      (data_control_read),
    .data_control_write     (data_control_write),
    .data_control_writedata (data_control_writedata),
    .data_control_readdata  (data_control_readdata),
    .src_valid              (src_valid),
    .src_data               (src_data),
    .src_last               (src_last),
    .src_ready              (src_ready),
    .snk_valid              (snk_valid),
    .snk_data               (snk_data),
    .snk_ready              (snk_ready)
  );

  always #5 clk_clk = ~clk_clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] in_buf [DEPTH];
  logic [31:0] core_q [$];

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] dat;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic ctrl_write(input logic [7:0] a, input logic [31:0] d);
    data_control_address   = a;
    data_control_writedata = d;
    data_control_write     = 1'b1;
    @(negedge clk_clk);
    data_control_write     = 1'b0;
  endtask

  task automatic ctrl_read(input logic [7:0] a, output logic [31:0] d);
    data_control_address = a;
    data_control_read    = 1'b1;
    @(negedge clk_clk);
    d                    = data_control_readdata;
    data_control_read    = 1'b0;
  endtask

  task automatic expect_reg(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    ctrl_read(a, d);
    check(name, 64'(d), 64'(exp));
  endtask

  task automatic load_input(input int n, input bit rnd, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      in_buf[i]         = rnd ? $urandom : base + 32'(i);
      data_in_write     = 1'b1;
      data_in_address   = 8'(i);
      data_in_writedata = in_buf[i];
      @(negedge clk_clk);
    end
    data_in_write = 1'b0;
  endtask

  task automatic check_outputs(input int n);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      data_out_address = 8'(i);
      @(negedge clk_clk);
      d = data_out_readdata;
      check($sformatf("out_buf[%0d]", i), 64'(d), 64'(in_buf[i] + 32'd1));
    end
  endtask

  // rdy_mode: 0 always ready, 1 every other cycle, 2 random.
  task automatic run_job(input int len, input int rdy_mode, input int vld_pct,
                         input int inject_cyc, input int abort_at, output bit aborted);
    int          in_n;
    int          out_n;
    bit          finished;
    bit          prev_stall;
    bit          prev_last;
    logic [31:0] prev_dat;
    logic        r;
    logic        sv;
    int          budget;
    in_n = 0; out_n = 0; finished = 0; prev_stall = 0; prev_last = 0; prev_dat = '0;
    aborted = 0;
    budget = len * 20 + 100;
    core_q.delete();
    ctrl_write(8'd1, 32'(len));
    ctrl_write(8'd0, 32'h1);
    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      if (abort_at > 0 && in_n == abort_at) begin
        reset_reset_n = 1'b0;
        src_ready = 1'b0;
        snk_valid = 1'b0;
        #1;
        check("reset_stream_outs", 64'({src_valid, src_last, snk_ready, src_data}), 64'(0));
        check("reset_bus_outs", 64'({data_control_readdata, data_out_readdata}), 64'(0));
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        core_q.delete();
        aborted = 1;
        return;
      end
      if (prev_stall) begin
        check("src_hold", 64'({src_valid, src_last, src_data}), 64'({1'b1, prev_last, prev_dat}));
      end
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2) == 0;
        default: r = 1'($urandom_range(0, 1));
      endcase
      src_ready = r;
      if (src_valid && r) begin
        if (in_n < len) begin
          check($sformatf("src_word[%0d]", in_n), 64'({src_last, src_data}),
                64'({(in_n == len - 1), in_buf[in_n]}));
        end else begin
          check("src_overrun", 64'(in_n), 64'(len - 1));
        end
        core_q.push_back(src_data + 32'd1);
        in_n++;
      end
      prev_stall = src_valid && !r;
      prev_dat   = src_data;
      prev_last  = src_last;
      sv = (core_q.size() > 0) && ($urandom_range(0, 99) < vld_pct);
      snk_valid = sv;
      snk_data  = sv ? core_q[0] : $urandom;
      if (sv && snk_ready) begin
        void'(core_q.pop_front());
        out_n++;
      end
      if (inject_cyc >= 0 && cyc == inject_cyc) begin
        data_in_write          = 1'b1;
        data_in_address        = 8'd0;
        data_in_writedata      = 32'hDEAD;
        data_control_write     = 1'b1;
        data_control_address   = 8'd0;
        data_control_writedata = 32'h1;
      end else if (inject_cyc >= 0 && cyc == inject_cyc + 1) begin
        data_in_write          = 1'b0;
        data_control_write     = 1'b1;
        data_control_address   = 8'd1;
        data_control_writedata = 32'd2;
      end else begin
        data_in_write      = 1'b0;
        data_control_write = 1'b0;
      end
      @(negedge clk_clk);
      if (in_n == len && out_n == len) finished = 1;
    end
    src_ready          = 1'b0;
    snk_valid          = 1'b0;
    data_in_write      = 1'b0;
    data_control_write = 1'b0;
    check("words_in", 64'(in_n), 64'(len));
    check("words_out", 64'(out_n), 64'(len));
    repeat (3) @(negedge clk_clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    bit          ab;
    int          n;

    reset_reset_n = 1'b0;
    data_in_write = 1'b0; data_in_writedata = '0; data_in_address = '0;
    data_out_address = '0;
    data_control_address = '0; data_control_read = 1'b0;
    data_control_write = 1'b0; data_control_writedata = '0;
    src_ready = 1'b0; snk_valid = 1'b0; snk_data = '0;
    repeat (2) @(negedge clk_clk);
    check("reset_stream", 64'({src_valid, src_last, snk_ready, src_data}), 64'(0));
    check("reset_bus", 64'({data_control_readdata, data_out_readdata}), 64'(0));
    reset_reset_n = 1'b1;
    @(negedge clk_clk);

    // Register map, write-only/read-only behaviour, length errors and CLR ordering.
    vecs[0]  = '{0, 8'd2, 32'h0};   vecs[1]  = '{0, 8'd1, 32'h0};
    vecs[2]  = '{0, 8'd3, 32'h0};   vecs[3]  = '{0, 8'd4, 32'h0};
    vecs[4]  = '{0, 8'd9, 32'h0};   vecs[5]  = '{1, 8'd1, 32'h5};
    vecs[6]  = '{0, 8'd1, 32'h5};   vecs[7]  = '{1, 8'd2, 32'hF};
    vecs[8]  = '{1, 8'd3, 32'h7};   vecs[9]  = '{0, 8'd2, 32'h0};
    vecs[10] = '{0, 8'd3, 32'h0};   vecs[11] = '{1, 8'd1, 32'h0};
    vecs[12] = '{1, 8'd0, 32'h1};   vecs[13] = '{0, 8'd2, 32'h4};
    vecs[14] = '{1, 8'd1, 32'd257}; vecs[15] = '{1, 8'd0, 32'h2};
    vecs[16] = '{0, 8'd2, 32'h0};   vecs[17] = '{1, 8'd0, 32'h1};
    vecs[18] = '{0, 8'd2, 32'h4};   vecs[19] = '{1, 8'd0, 32'h3};
    vecs[20] = '{0, 8'd2, 32'h4};   vecs[21] = '{1, 8'd0, 32'h2};
    vecs[22] = '{0, 8'd1, 32'd257};
    for (int i = 0; i < 23; i++) begin
      if (vecs[i].wr) begin
        ctrl_write(vecs[i].addr, vecs[i].dat);
      end else begin
        ctrl_read(vecs[i].addr, d);
        check($sformatf("reg_vec%0d", i), 64'(d), 64'(vecs[i].dat));
      end
    end

    // Loopback with continuous flow.
    load_input(4, 0, 32'h10);
    run_job(4, 0, 100, -1, 0, ab);
    check_outputs(4);
    expect_reg("loop_status", 8'd2, 32'h2);
    expect_reg("loop_outcnt", 8'd3, 32'd4);
`ifdef MEMORY_IO_CYCLE_COUNTER_EN
    ctrl_read(8'd4, d);
    check("loop_cycles_range", 64'(d >= 32'd4 && d <= 32'd12), 64'(1));
`endif

    // Alternating src_ready, bursty results.
    load_input(8, 1, 32'h0);
    run_job(8, 1, 50, -1, 0, ab);
    check_outputs(8);
    expect_reg("bp_status", 8'd2, 32'h2);

    // Input write, second START and LENGTH rewrite while busy.
    load_input(6, 1, 32'h0);
    run_job(6, 2, 70, 3, 0, ab);
    repeat (10) @(negedge clk_clk);
    expect_reg("busy_status", 8'd2, 32'hA);
    expect_reg("busy_outcnt", 8'd3, 32'd6);
    expect_reg("busy_length", 8'd1, 32'd2);
    check_outputs(6);
    ctrl_write(8'd0, 32'h2);
    run_job(1, 0, 100, -1, 0, ab);
    expect_reg("busy_rerun_status", 8'd2, 32'h2);

    // Reset in the middle of a run.
    load_input(8, 1, 32'h0);
    run_job(8, 0, 100, -1, 3, ab);
    check("reset_aborted", 64'(ab), 64'(1));
    expect_reg("post_reset_status", 8'd2, 32'h0);
    expect_reg("post_reset_length", 8'd1, 32'h0);
    expect_reg("post_reset_outcnt", 8'd3, 32'h0);
    load_input(2, 1, 32'h0);
    run_job(2, 2, 60, -1, 0, ab);
    check_outputs(2);
    expect_reg("post_reset_run_status", 8'd2, 32'h2);

    // Full depth.
    load_input(DEPTH, 1, 32'h0);
    run_job(DEPTH, 2, 80, -1, 0, ab);
    check_outputs(DEPTH);
    expect_reg("full_outcnt", 8'd3, 32'(DEPTH));
    expect_reg("full_status", 8'd2, 32'h2);

    // Random lengths and handshake densities.
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 24);
      load_input(n, 1, 32'h0);
      run_job(n, 2, $urandom_range(30, 100), -1, 0, ab);
      check_outputs(n);
      expect_reg($sformatf("rand%0d_outcnt", k), 8'd3, 32'(n));
      expect_reg($sformatf("rand%0d_status", k), 8'd2, 32'h2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
